radix_shift_register: RTL and testbench

Parametrised digit-serial shift register for the Montgomery datapath. It holds one operand of WIDTH bits and presents it DIGIT bits at a time, LSB-first or MSB-first, to the multiplier's digit-select logic. It generalises the fixed 1028-bit, radix-4 operand shifter with a configurable radix and scan direction. It adds a digit counter, busy/last/done status and defined load/shift priority.

---
 rtl/mont_pkg.sv | 22 ++
 rtl/radix_shift_register_if.sv | 29 ++
 rtl/radix_shift_register.sv | 78 +++++++
 tb/tb_radix_shift_register.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared Montgomery datapath package: default operand geometry, digit-count
// helpers and the scan state encoding used by the operand shifter.
package mont_pkg;

  localparam int DEF_WIDTH = 1028;
  localparam int DEF_DIGIT = 2;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} scan_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int ndigits(input int w, input int d);
    return (w + d - 1) / d;
  endfunction

endpackage

// File: rtl/radix_shift_register_if.sv
// Load/shift request and digit/status response bundle for radix_shift_register.
interface radix_shift_register_if #(
  parameter int WIDTH = mont_pkg::DEF_WIDTH,
  parameter int DIGIT = mont_pkg::DEF_DIGIT
);
  localparam int NDIGITS = mont_pkg::ndigits(WIDTH, DIGIT);
  localparam int CW      = mont_pkg::clog2(NDIGITS + 1);

  logic             load;
  logic [WIDTH-1:0] in_number;
  logic             shift;
  logic [WIDTH-1:0] out_shift;
  logic [DIGIT-1:0] digit;
  logic [CW-1:0]    count;
  logic             busy;
  logic             last;
  logic             shift_done;
  logic             done;

  modport master (
    output load, in_number, shift,
    input  out_shift, digit, count, busy, last, shift_done, done
  );

  modport slave (
    input  load, in_number, shift,
    output out_shift, digit, count, busy, last, shift_done, done
  );
endinterface

// File: rtl/radix_shift_register.sv
// Digit-serial operand shifter: holds a WIDTH-bit operand in a zero-padded
// register and presents it DIGIT bits per shift, LSB- or MSB-first.
module radix_shift_register #(
  parameter int WIDTH     = mont_pkg::DEF_WIDTH,
  parameter int DIGIT     = mont_pkg::DEF_DIGIT,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               rest,
  radix_shift_register_if.slave bus
);
  import mont_pkg::*;

  localparam int NDIGITS = ndigits(WIDTH, DIGIT);
  localparam int PWIDTH  = NDIGITS * DIGIT;
  localparam int CW      = clog2(NDIGITS + 1);

  scan_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PWIDTH-1:0] reg_q, reg_d;
  logic              sd_q, sd_d;
  logic              dn_q, dn_d;

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      reg_q   <= '0;
      sd_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      sd_q    <= sd_d;
      dn_q    <= dn_d;
    end
  end

  // Load beats shift; a shift only lands while a scan is active.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    sd_d    = 1'b0;
    dn_d    = 1'b0;
    if (bus.load) begin
      reg_d   = PWIDTH'(bus.in_number);
      cnt_d   = CW'(NDIGITS);
      state_d = ACTIVE;
    end else if (state_q == ACTIVE && bus.shift) begin
      reg_d = MSB_FIRST ? (reg_q << DIGIT) : (reg_q >> DIGIT);
      cnt_d = cnt_q - CW'(1);
      sd_d  = 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        dn_d    = 1'b1;
      end
    end
  end

  // Pad bits sit at the top, so MSB-first scans see them in the first digit.
  generate
    if (MSB_FIRST) begin : g_msb
      assign bus.digit = reg_q[PWIDTH-1 -: DIGIT];
    end else begin : g_lsb
      assign bus.digit = reg_q[DIGIT-1:0];
    end
  endgenerate

  assign bus.out_shift  = reg_q[WIDTH-1:0];
  assign bus.count      = cnt_q;
  assign bus.busy       = (cnt_q != '0);
  assign bus.last       = (cnt_q == CW'(1));
  assign bus.shift_done = sd_q;
  assign bus.done       = dn_q;

endmodule

// File: tb/tb_radix_shift_register.sv
// Bench for radix_shift_register: four small builds (8/7 bit, LSB/MSB first)
// share one stimulus stream, plus the default 1028-bit build.
module tb_radix_shift_register;
  logic clk = 1'b0;
  logic rest;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       ld, sh;
  logic [7:0] din;
  logic       ld_d, sh_d;

  radix_shift_register_if #(.WIDTH(8), .DIGIT(2)) i8l ();
  radix_shift_register_if #(.WIDTH(8), .DIGIT(2)) i8m ();
  radix_shift_register_if #(.WIDTH(7), .DIGIT(2)) i7l ();
  radix_shift_register_if #(.WIDTH(7), .DIGIT(2)) i7m ();
  radix_shift_register_if #(.WIDTH(1028), .DIGIT(2)) idf ();

  assign i8l.load = ld; assign i8l.shift = sh; assign i8l.in_number = din;
  assign i8m.load = ld; assign i8m.shift = sh; assign i8m.in_number = din;
  assign i7l.load = ld; assign i7l.shift = sh; assign i7l.in_number = din[6:0];
  assign i7m.load = ld; assign i7m.shift = sh; assign i7m.in_number = din[6:0];
  assign idf.load = ld_d; assign idf.shift = sh_d; assign idf.in_number = '1;

  radix_shift_register #(.WIDTH(8), .DIGIT(2), .MSB_FIRST(1'b0)) u8l (.clk(clk), .rest(rest), .bus(i8l));
  radix_shift_register #(.WIDTH(8), .DIGIT(2), .MSB_FIRST(1'b1)) u8m (.clk(clk), .rest(rest), .bus(i8m));
  radix_shift_register #(.WIDTH(7), .DIGIT(2), .MSB_FIRST(1'b0)) u7l (.clk(clk), .rest(rest), .bus(i7l));
  radix_shift_register #(.WIDTH(7), .DIGIT(2), .MSB_FIRST(1'b1)) u7m (.clk(clk), .rest(rest), .bus(i7m));
  radix_shift_register #(.WIDTH(1028), .DIGIT(2), .MSB_FIRST(1'b0)) udf (.clk(clk), .rest(rest), .bus(idf));

  // Outputs of the four small builds gathered for indexed checking.
  logic [7:0] os [4];
  logic [1:0] dg [4];
  logic [2:0] cn [4];
  logic       bs [4], ls [4], sd [4], dn [4];
  assign os[0] = i8l.out_shift;         assign os[1] = i8m.out_shift;
  assign os[2] = {1'b0, i7l.out_shift}; assign os[3] = {1'b0, i7m.out_shift};
  assign dg[0] = i8l.digit; assign dg[1] = i8m.digit; assign dg[2] = i7l.digit; assign dg[3] = i7m.digit;
  assign cn[0] = i8l.count; assign cn[1] = i8m.count; assign cn[2] = i7l.count; assign cn[3] = i7m.count;
  assign bs[0] = i8l.busy; assign bs[1] = i8m.busy; assign bs[2] = i7l.busy; assign bs[3] = i7m.busy;
  assign ls[0] = i8l.last; assign ls[1] = i8m.last; assign ls[2] = i7l.last; assign ls[3] = i7m.last;
  assign sd[0] = i8l.shift_done; assign sd[1] = i8m.shift_done;
  assign sd[2] = i7l.shift_done; assign sd[3] = i7m.shift_done;
  assign dn[0] = i8l.done; assign dn[1] = i8m.done; assign dn[2] = i7l.done; assign dn[3] = i7m.done;

  int W  [4] = '{8, 8, 7, 7};
  bit MF [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rest = 1'b1; ld = 1'b0; sh = 1'b0; din = '0; ld_d = 1'b0; sh_d = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({os[i], dg[i], cn[i], bs[i], ls[i], sd[i], dn[i]} !== 17'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: out=%h dig=%0d cnt=%0d busy=%b last=%b sd=%b done=%b, want all 0",
                 i, os[i], dg[i], cn[i], bs[i], ls[i], sd[i], dn[i]);
      end
    end
    n_cmp++;
    if (idf.count !== 10'd0 || idf.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_default: count=%0d busy=%b, want 0 0", idf.count, idf.busy);
    end
    rest = 1'b0;
    tick();
  endtask

  task automatic test_lsb_scan();
    logic [1:0] ed [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    ld = 1'b1; din = 8'hB4; tick(); ld = 1'b0;
    n_cmp++;
    if (i8l.out_shift !== 8'hB4 || i8l.busy !== 1'b1) begin
      n_err++; $display("FAIL lsb_load: out=%h busy=%b, want b4 1", i8l.out_shift, i8l.busy);
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (i8l.digit !== ed[j] || i8l.count !== 3'(4 - j) || i8l.last !== (j == 3)) begin
        n_err++;
        $display("FAIL lsb_digit%0d: dig=%0d cnt=%0d last=%b, want %0d %0d %b",
                 j, i8l.digit, i8l.count, i8l.last, ed[j], 4 - j, j == 3);
      end
      sh = 1'b1; tick();
      n_cmp++;
      if (i8l.shift_done !== 1'b1 || i8l.done !== (j == 3)) begin
        n_err++;
        $display("FAIL lsb_pulse%0d: sd=%b done=%b, want 1 %b", j, i8l.shift_done, i8l.done, j == 3);
      end
    end
    sh = 1'b0;
    n_cmp++;
    if (i8l.busy !== 1'b0 || i8l.out_shift !== 8'h00 || i8l.digit !== 2'd0) begin
      n_err++;
      $display("FAIL lsb_end: busy=%b out=%h dig=%0d, want 0 00 0", i8l.busy, i8l.out_shift, i8l.digit);
    end
    tick();
    n_cmp++;
    if (i8l.done !== 1'b0 || i8l.shift_done !== 1'b0) begin
      n_err++; $display("FAIL lsb_pulse_len: done=%b sd=%b, want 0 0", i8l.done, i8l.shift_done);
    end
  endtask

  task automatic test_msb_scan();
    logic [1:0] ed [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
    ld = 1'b1; din = 8'hB4; tick(); ld = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (i8m.digit !== ed[j] || i8m.count !== 3'(4 - j)) begin
        n_err++;
        $display("FAIL msb_digit%0d: dig=%0d cnt=%0d, want %0d %0d", j, i8m.digit, i8m.count, ed[j], 4 - j);
      end
      sh = 1'b1; tick();
      if (j == 0) begin
        n_cmp++;
        if (i8m.out_shift !== 8'hD0) begin
          n_err++; $display("FAIL msb_out1: out=%h, want d0", i8m.out_shift);
        end
      end
    end
    sh = 1'b0;
    n_cmp++;
    if (i8m.done !== 1'b1 || i8m.busy !== 1'b0) begin
      n_err++; $display("FAIL msb_done: done=%b busy=%b, want 1 0", i8m.done, i8m.busy);
    end
    tick();
  endtask

  task automatic test_padding();
    logic [1:0] el [4] = '{2'd3, 2'd3, 2'd3, 2'd1};
    logic [1:0] em [4] = '{2'd1, 2'd3, 2'd3, 2'd3};
    ld = 1'b1; din = 8'h7F; tick(); ld = 1'b0;
    n_cmp++;
    if (i7l.count !== 3'd4 || i7l.out_shift !== 7'h7F) begin
      n_err++; $display("FAIL pad_load: cnt=%0d out=%h, want 4 7f", i7l.count, i7l.out_shift);
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (i7l.digit !== el[j] || i7m.digit !== em[j]) begin
        n_err++;
        $display("FAIL pad_digit%0d: lsb=%0d msb=%0d, want %0d %0d", j, i7l.digit, i7m.digit, el[j], em[j]);
      end
      n_cmp++;
      if (i7l.done !== 1'b0 || i7m.done !== 1'b0) begin
        n_err++; $display("FAIL pad_early_done%0d: lsb=%b msb=%b, want 0 0", j, i7l.done, i7m.done);
      end
      sh = 1'b1; tick();
    end
    sh = 1'b0;
    n_cmp++;
    if (i7l.done !== 1'b1 || i7m.done !== 1'b1 || i7m.out_shift !== 7'h00) begin
      n_err++;
      $display("FAIL pad_done: lsb=%b msb=%b out=%h, want 1 1 00", i7l.done, i7m.done, i7m.out_shift);
    end
    tick();
  endtask

  task automatic test_load_vs_shift();
    ld = 1'b1; din = 8'h1E; tick(); ld = 1'b0;
    sh = 1'b1; tick(); tick();
    n_cmp++;
    if (i8l.count !== 3'd2) begin
      n_err++; $display("FAIL lvs_pre: cnt=%0d, want 2", i8l.count);
    end
    ld = 1'b1; sh = 1'b1; din = 8'h1E; tick(); ld = 1'b0; sh = 1'b0;
    n_cmp++;
    if (i8l.count !== 3'd4 || i8l.digit !== 2'd2 || i8l.shift_done !== 1'b0 || i8l.out_shift !== 8'h1E) begin
      n_err++;
      $display("FAIL lvs: cnt=%0d dig=%0d sd=%b out=%h, want 4 2 0 1e",
               i8l.count, i8l.digit, i8l.shift_done, i8l.out_shift);
    end
    sh = 1'b1; tick(); tick(); tick(); tick(); sh = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    ld = 1'b1; din = 8'hB4; tick(); ld = 1'b0;
    sh = 1'b1; tick(); sh = 1'b0;
    rest = 1'b1; tick(); rest = 1'b0;
    n_cmp++;
    if ({i8l.out_shift, i8l.digit, i8l.count, i8l.busy, i8l.last, i8l.shift_done, i8l.done} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_mid: out=%h dig=%0d cnt=%0d busy=%b sd=%b, want all 0",
               i8l.out_shift, i8l.digit, i8l.count, i8l.busy, i8l.shift_done);
    end
    sh = 1'b1; tick(); sh = 1'b0;
    n_cmp++;
    if (i8l.shift_done !== 1'b0 || i8l.count !== 3'd0) begin
      n_err++; $display("FAIL reset_mid_shift: sd=%b cnt=%0d, want 0 0", i8l.shift_done, i8l.count);
    end
  endtask

  task automatic test_idle_shift();
    sh = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (sd[i] !== 1'b0 || dn[i] !== 1'b0 || cn[i] !== 3'd0 || os[i] !== 8'h00) begin
          n_err++;
          $display("FAIL idle_shift[%0d]: sd=%b done=%b cnt=%0d out=%h, want 0 0 0 00",
                   i, sd[i], dn[i], cn[i], os[i]);
        end
      end
    end
    sh = 1'b0;
  endtask

  // Reference: operand value plus digits consumed; outputs follow from arithmetic.
  task automatic test_random();
    logic [15:0] m_op [4];
    int          m_cnt [4], m_k [4];
    bit          m_sd [4], m_dn [4];
    logic [15:0] p, v;
    logic [7:0]  mask, e_out;
    logic [1:0]  e_dig;
    rest = 1'b1; ld = 1'b0; sh = 1'b0; tick(); rest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_op[i] = '0; m_cnt[i] = 0; m_k[i] = 4; m_sd[i] = 0; m_dn[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      rest = ($urandom_range(0, 59) == 0);
      ld   = ($urandom_range(0, 5) == 0);
      sh   = ($urandom_range(0, 2) != 0);
      din  = 8'($urandom);
      tick();
      for (int i = 0; i < 4; i++) begin
        mask = (W[i] == 8) ? 8'hFF : 8'h7F;
        m_sd[i] = 0; m_dn[i] = 0;
        if (rest) begin
          m_op[i] = '0; m_cnt[i] = 0; m_k[i] = 4;
        end else if (ld) begin
          m_op[i] = {8'h00, din & mask}; m_cnt[i] = 4; m_k[i] = 0;
        end else if (sh && m_cnt[i] > 0) begin
          m_cnt[i]--; m_k[i]++; m_sd[i] = 1; m_dn[i] = (m_cnt[i] == 0);
        end
        p = m_op[i];
        if (!MF[i]) begin
          v = p >> (2 * m_k[i]);
          e_dig = v[1:0];
        end else begin
          v = p << (2 * m_k[i]);
          e_dig = (m_k[i] < 4) ? 2'((p >> (6 - 2 * m_k[i])) & 16'd3) : 2'd0;
        end
        e_out = v[7:0] & mask;
        n_cmp++;
        if (os[i] !== e_out || dg[i] !== e_dig || cn[i] !== 3'(m_cnt[i])) begin
          n_err++;
          $display("FAIL rand[%0d] c%0d: out=%h dig=%0d cnt=%0d, want %h %0d %0d",
                   i, c, os[i], dg[i], cn[i], e_out, e_dig, m_cnt[i]);
        end
        n_cmp++;
        if (bs[i] !== (m_cnt[i] != 0) || ls[i] !== (m_cnt[i] == 1) || sd[i] !== m_sd[i] || dn[i] !== m_dn[i]) begin
          n_err++;
          $display("FAIL rand_stat[%0d] c%0d: busy=%b last=%b sd=%b done=%b, want %b %b %b %b",
                   i, c, bs[i], ls[i], sd[i], dn[i], m_cnt[i] != 0, m_cnt[i] == 1, m_sd[i], m_dn[i]);
        end
      end
    end
    rest = 1'b0; ld = 1'b0; sh = 1'b0;
    tick();
  endtask

  task automatic test_default_build();
    int n_done, done_at;
    n_done = 0; done_at = -1;
    ld_d = 1'b1; tick(); ld_d = 1'b0;
    n_cmp++;
    if (idf.count !== 10'd514 || idf.digit !== 2'd3 || idf.out_shift !== {1028{1'b1}}) begin
      n_err++; $display("FAIL def_load: cnt=%0d dig=%0d, want 514 3", idf.count, idf.digit);
    end
    sh_d = 1'b1;
    for (int n = 1; n <= 530; n++) begin
      tick();
      if (idf.done === 1'b1) begin
        n_done++;
        done_at = n;
      end
    end
    sh_d = 1'b0;
    n_cmp++;
    if (n_done != 1 || done_at != 514) begin
      n_err++; $display("FAIL def_done: pulses=%0d at_shift=%0d, want 1 514", n_done, done_at);
    end
    n_cmp++;
    if (idf.busy !== 1'b0 || idf.out_shift !== '0) begin
      n_err++; $display("FAIL def_end: busy=%b, want 0 with zero register", idf.busy);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_scan();
    test_msb_scan();
    test_padding();
    test_load_vs_shift();
    test_reset_mid();
    test_idle_shift();
    test_random();
    test_default_build();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
